// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file BIST: default widths, FSM encoding
// and the march pattern generator.
package regfile_pkg;

  localparam int DW_DEF   = 32;
  localparam int AWID_DEF = 5;
  localparam logic [31:0] SEED_DEF = 32'hA5A5_0000;

  // Widest data/address the pattern helper handles; callers truncate the result.
  localparam int MAX_DW   = 64;
  localparam int MAX_AWID = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_R0,
    S_F0,
    S_W1,
    S_R1,
    S_F1,
    S_DONE
  } state_e;

  // P0(a) = seed + a, P1(a) = ~P0(a). Truncating to DW afterwards gives the
  // sum modulo 2**DW.
  function automatic logic [MAX_DW-1:0] pat(input logic                pass_sel,
                                            input logic [MAX_AWID-1:0] addr,
                                            input logic [MAX_DW-1:0]   seed);
    logic [MAX_DW-1:0] p0;
    p0 = seed + MAX_DW'(addr);
    return pass_sel ? ~p0 : p0;
  endfunction

endpackage

// File: rtl/regfile_bist_chk.sv
// Read-data checker: aligns each issued read with its returned data through a
// RD_LAT-deep tag pipeline, compares both ports, counts mismatches with
// saturation and remembers where the first one happened.
module regfile_bist_chk
  import regfile_pkg::*;
#(
  parameter int              DW      = DW_DEF,
  parameter int              AWID    = AWID_DEF,
  parameter int              RD_LAT  = 1,
  parameter logic [DW-1:0]   SEED    = DW'(SEED_DEF),
  parameter bit              ZERO_R0 = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push_vld,
  input  logic            push_pass,
  input  logic [AWID-1:0] push_addr,
  input  logic [DW-1:0]   rd1,
  input  logic [DW-1:0]   rd2,
  output logic [7:0]      err_cnt,
  output logic [AWID-1:0] fail_addr,
  output logic            fail_port
);

  typedef struct packed {
    logic            vld;
    logic            pass_sel;
    logic [AWID-1:0] addr;
  } tag_t;

  tag_t            pipe_q [RD_LAT];
  tag_t            pipe_d [RD_LAT];
  tag_t            head;
  logic [AWID-1:0] addr1;
  logic [AWID-1:0] addr2;
  logic [DW-1:0]   exp1;
  logic [DW-1:0]   exp2;
  logic            mis1;
  logic            mis2;
  logic [8:0]      sum;
  logic [7:0]      err_cnt_q,   err_cnt_d;
  logic [AWID-1:0] fail_addr_q, fail_addr_d;
  logic            fail_port_q, fail_port_d;

  // Expected read value; address 0 may be hardwired to zero in the target.
  function automatic logic [DW-1:0] exp_val(input logic pass_sel, input logic [AWID-1:0] addr);
    if (ZERO_R0 && addr == '0) return '0;
    return DW'(pat(pass_sel, MAX_AWID'(addr), MAX_DW'(SEED)));
  endfunction

  // Tag pipeline: a read issued now is compared RD_LAT edges later.
  always_comb begin
    pipe_d[0] = '{vld: push_vld, pass_sel: push_pass, addr: push_addr};
    for (int k = 1; k < RD_LAT; k++) pipe_d[k] = pipe_q[k-1];
  end

  // Dual compare, saturating error count and first-fail capture.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_port_d = fail_port_q;
    head        = pipe_q[RD_LAT-1];
    addr1       = head.addr;
    addr2       = ~head.addr;
    exp1        = exp_val(head.pass_sel, addr1);
    exp2        = exp_val(head.pass_sel, addr2);
    mis1        = head.vld && (rd1 != exp1);
    mis2        = head.vld && (rd2 != exp2);
    sum         = {1'b0, err_cnt_q} + 9'(mis1) + 9'(mis2);
    if (clear) begin
      err_cnt_d   = '0;
      fail_addr_d = '0;
      fail_port_d = 1'b0;
    end else begin
      err_cnt_d = (sum > 9'd255) ? 8'hFF : sum[7:0];
      // A zero count means nothing failed yet this run (it never wraps back).
      if (err_cnt_q == '0 && (mis1 || mis2)) begin
        fail_addr_d = mis1 ? addr1 : addr2;
        fail_port_d = !mis1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tag pipeline is tiny and its valid bits must be clean, so it is reset like any flop.
      for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_port_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int k = 0; k < RD_LAT; k++) pipe_q[k] <= pipe_d[k];
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_port_q <= fail_port_d;
    end
  end

  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_port = fail_port_q;

endmodule

// File: rtl/regfile_bist.sv
// Register-file BIST initiator: two-pass march (pattern, inverted pattern) over
// every address, writing then reading both ports in opposite address order.
module regfile_bist
  import regfile_pkg::*;
#(
  parameter int            DW      = DW_DEF,
  parameter int            AWID    = AWID_DEF,
  parameter int            RD_LAT  = 1,
  parameter logic [DW-1:0] SEED    = DW'(SEED_DEF),
  parameter bit            ZERO_R0 = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_cnt,
  output logic [AWID-1:0] fail_addr,
  output logic            fail_port,
  output logic            EN,
  output logic            WR,
  output logic [AWID-1:0] AW,
  output logic [DW-1:0]   WD3,
  output logic            RD,
  output logic [AWID-1:0] AR_1,
  output logic [AWID-1:0] AR_2,
  input  logic [DW-1:0]   RD1,
  input  logic [DW-1:0]   RD2
);

  localparam logic [AWID-1:0] LAST_ADDR  = '1;
  localparam logic [AWID-1:0] LAST_FLUSH = AWID'(RD_LAT - 1);

  state_e          state_q, state_d;
  logic [AWID-1:0] cnt_q,   cnt_d;
  logic            accept;
  logic            wr_phase;
  logic            rd_phase;
  logic            pass_sel;

  // Next-state and address counter; the counter returns to 0 only on a state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_W0;
          cnt_d   = '0;
          accept  = 1'b1;
        end
      end
      S_W0, S_R0, S_W1, S_R1: begin
        if (cnt_q == LAST_ADDR) begin
          cnt_d = '0;
          unique case (state_q)
            S_W0:    state_d = S_R0;
            S_R0:    state_d = S_F0;
            S_W1:    state_d = S_R1;
            default: state_d = S_F1;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_F0, S_F1: begin
        if (cnt_q == LAST_FLUSH) begin
          cnt_d   = '0;
          state_d = (state_q == S_F0) ? S_W1 : S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes and buses decode straight from flops, so reset clears them without an edge.
  always_comb begin
    wr_phase = (state_q == S_W0) || (state_q == S_W1);
    rd_phase = (state_q == S_R0) || (state_q == S_R1);
    pass_sel = (state_q == S_W1) || (state_q == S_R1) || (state_q == S_F1);
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = (state_q == S_DONE);
    EN       = busy;
    WR       = wr_phase;
    RD       = rd_phase;
    AW       = wr_phase ? cnt_q : '0;
    WD3      = wr_phase ? DW'(pat(pass_sel, MAX_AWID'(cnt_q), MAX_DW'(SEED))) : '0;
    AR_1     = rd_phase ? cnt_q : '0;
    AR_2     = rd_phase ? ~cnt_q : '0;
    pass     = done && (err_cnt == '0);
  end

  regfile_bist_chk #(
    .DW      (DW),
    .AWID    (AWID),
    .RD_LAT  (RD_LAT),
    .SEED    (SEED),
    .ZERO_R0 (ZERO_R0)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .push_vld  (rd_phase),
    .push_pass (pass_sel),
    .push_addr (cnt_q),
    .rd1       (RD1),
    .rd2       (RD2),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_port (fail_port)
  );

endmodule
